// File: rtl/product_stream_collector_if.sv
// product_stream_collector_if: input stream, output stream and error flag of the collector.
interface product_stream_collector_if #(
    parameter int REGISTER_SIZE = 32
);
    logic [REGISTER_SIZE-1:0] data_in;
    logic [REGISTER_SIZE-1:0] data_out;
    logic valid_in;
    logic final_in;
    logic ready_out;
    logic valid_out;
    logic final_out;
    logic ready_in;
    logic error_out;
    modport slave (
        input  data_in, valid_in, final_in, ready_in,
        output ready_out, data_out, valid_out, final_out, error_out
    );
    modport master (
        output data_in, valid_in, final_in, ready_in,
        input  ready_out, data_out, valid_out, final_out, error_out
    );
endinterface

// File: rtl/product_stream_collector.sv
// product_stream_collector: buffers one product stream in block RAM, then replays it in order.
// Define COLLECTOR_LENGTH_CHECK_EN to also flag streams whose length differs from DEPTH.
module product_stream_collector #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM = 4096
) (
    input logic clk_in,
    input logic rst_in,
    product_stream_collector_if.slave bus
);
    localparam int DEPTH = 2 * BITS_IN_NUM / REGISTER_SIZE;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, RECEIVING, SENDING} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] ptr_q, ptr_d, raddr, waddr;
    logic vld_q, vld_d, err_q, err_d;
    logic [REGISTER_SIZE-1:0] mem [DEPTH];
    logic [REGISTER_SIZE-1:0] rdata_q;
    logic xfer_in, xfer_out, last, full, we;
    assign xfer_in = bus.valid_in && bus.ready_out;
    assign xfer_out = vld_q && bus.ready_in;
    assign last = {1'b0, ptr_q} == cnt_q - CW'(1);
    assign full = cnt_q == CW'(DEPTH);
    assign bus.ready_out = state_q != SENDING;
    assign bus.valid_out = vld_q;
    assign bus.final_out = vld_q && last;
    assign bus.data_out = vld_q ? rdata_q : '0;
    assign bus.error_out = err_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        vld_d = vld_q;
        err_d = err_q;
        we = 1'b0;
        waddr = cnt_q[AW-1:0];
        // re-reading the presented address on a stall keeps data_out stable
        raddr = xfer_out ? ptr_q + AW'(1) : ptr_q;
        case (state_q)
            IDLE: begin
                ptr_d = '0;
                if (xfer_in) begin
                    we = 1'b1;
                    waddr = '0;
                    cnt_d = CW'(1);
                    err_d = 1'b0;
                    state_d = bus.final_in ? SENDING : RECEIVING;
                end
            end
            RECEIVING: if (xfer_in) begin
                we = !full;
                cnt_d = full ? cnt_q : cnt_q + CW'(1);
                err_d = err_q || (full && !bus.final_in);
                state_d = bus.final_in ? SENDING : RECEIVING;
            end
            SENDING: begin
                vld_d = !(xfer_out && last);
                ptr_d = raddr;
                state_d = (xfer_out && last) ? IDLE : SENDING;
            end
            default: state_d = IDLE;
        endcase
`ifdef COLLECTOR_LENGTH_CHECK_EN
        if (xfer_in && bus.final_in && cnt_d != CW'(DEPTH)) err_d = 1'b1;
`endif
    end
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q <= '0;
            ptr_q <= '0;
            vld_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end
    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= bus.data_in;
        rdata_q <= mem[raddr];
    end
endmodule

// File: tb/tb_product_stream_collector.sv
// tb_product_stream_collector: table-driven stream vectors plus reset and sticky-error sequences.
module tb_product_stream_collector;
`ifdef COLLECTOR_LENGTH_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    product_stream_collector_if #(.REGISTER_SIZE(32)) bus();
    product_stream_collector #(.REGISTER_SIZE(32), .BITS_IN_NUM(4096)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        int n;
        logic [31:0] base;
        int mode;
        int exp_n;
        bit exp_err;
    } vec_t;
    vec_t vecs [5];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input int n, input logic [31:0] base, input bit fin, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, "/ready_out_rx"}, 32'(bus.ready_out), 1);
            bus.valid_in = 1'b1;
            bus.data_in = base + i;
            bus.final_in = fin && (i == n - 1);
            step();
        end
        bus.valid_in = 1'b0;
        bus.final_in = 1'b0;
        bus.data_in = '0;
    endtask
    task automatic run_vec(input vec_t v, input string tag);
        int got = 0;
        int lat = 0;
        int k = 0;
        bit stalled = 0;
        bit done = 0;
        logic [31:0] held = '0;
        send(v.n, v.base, 1'b1, tag);
        chk({tag, "/ready_out_tx"}, 32'(bus.ready_out), 0);
        while (!done && k < 4000) begin
            bus.ready_in = (v.mode == 0) ? 1'b1 : (k % 4 == 0 || k % 4 == 3);
            if (got == 0 && !bus.valid_out) lat++;
            if (stalled) begin
                chk({tag, "/hold_valid"}, 32'(bus.valid_out), 1);
                chk({tag, "/hold_data"}, bus.data_out, held);
            end
            if (bus.valid_out && bus.ready_in) begin
                chk($sformatf("%s/data%0d", tag, got), bus.data_out, v.base + got);
                chk($sformatf("%s/final%0d", tag, got), 32'(bus.final_out), 32'(got == v.exp_n - 1));
                got++;
                done = bus.final_out;
                stalled = 0;
            end else if (bus.valid_out) begin
                stalled = 1;
                held = bus.data_out;
            end
            step();
            k++;
        end
        bus.ready_in = 1'b0;
        chk({tag, "/done"}, 32'(done), 1);
        chk({tag, "/latency_ok"}, 32'(lat <= 3), 1);
        chk({tag, "/count"}, got, v.exp_n);
        chk({tag, "/error_out"}, 32'(bus.error_out), 32'(v.exp_err));
        chk({tag, "/idle_valid"}, 32'(bus.valid_out), 0);
        chk({tag, "/idle_ready"}, 32'(bus.ready_out), 1);
    endtask
    initial begin
        vecs[0] = '{n: 256, base: 32'h0, mode: 0, exp_n: 256, exp_err: 1'b0};
        vecs[1] = '{n: 256, base: 32'h0, mode: 1, exp_n: 256, exp_err: 1'b0};
        vecs[2] = '{n: 10, base: 32'hA0, mode: 0, exp_n: 10, exp_err: CHK};
        vecs[3] = '{n: 1, base: 32'hDEADBEEF, mode: 1, exp_n: 1, exp_err: CHK};
        vecs[4] = '{n: 258, base: 32'h0, mode: 0, exp_n: 256, exp_err: 1'b1};
        bus.data_in = '0;
        bus.valid_in = 1'b0;
        bus.final_in = 1'b0;
        bus.ready_in = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("reset/ready_out", 32'(bus.ready_out), 1);
        chk("reset/valid_out", 32'(bus.valid_out), 0);
        chk("reset/final_out", 32'(bus.final_out), 0);
        chk("reset/error_out", 32'(bus.error_out), 0);
        chk("reset/data_out", bus.data_out, 0);
        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));
        // overflow error must persist while idle, then clear on reset
        bus.valid_in = 1'b0;
        repeat (5) step();
        chk("sticky/error_out", 32'(bus.error_out), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_err/error_out", 32'(bus.error_out), 0);
        send(100, 32'h5000, 1'b0, "abort");
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort/valid_out", 32'(bus.valid_out), 0);
        chk("abort/ready_out", 32'(bus.ready_out), 1);
        chk("abort/data_out", bus.data_out, 0);
        run_vec('{n: 256, base: 32'h1000, mode: 0, exp_n: 256, exp_err: 1'b0}, "after_rst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/product_stream_collector.md
PRODUCT_STREAM_COLLECTOR -- requirements
Module: product_stream_collector

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 32, block width in bits.
REQ-002 SHALL have parameter BITS_IN_NUM, default 4096, operand width; DEPTH = 2*BITS_IN_NUM/REGISTER_SIZE (256) blocks per product stream.
REQ-003 SHALL have clk_in  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have rst_in  input  1  reset, synchronous and active-low.
REQ-005 SHALL have data_in  input  REGISTER_SIZE  incoming product block, least-significant block first.
REQ-006 SHALL have valid_in  input  1  data_in carries a block this cycle.
REQ-007 SHALL have final_in  input  1  qualifies valid_in beat as last block of stream.
REQ-008 SHALL have ready_out  output  1  collector accepts input beats (high in IDLE and RECEIVING only).
REQ-009 SHALL have data_out  output  REGISTER_SIZE  outgoing block, same order as received.
REQ-010 SHALL have valid_out  output  1  data_out valid.
REQ-011 SHALL have final_out  output  1  data_out is last stored block; only with valid_out.
REQ-012 SHALL have ready_in  input  1  downstream accepts data_out this cycle.
REQ-013 SHALL have error_out  output  1  sticky stream-length error for current stream.

Function
REQ-014 SHALL implement states IDLE, RECEIVING, SENDING; a beat transfers on input when valid_in && ready_out, on output when valid_out && ready_in.
REQ-015 SHALL, in IDLE, on transfer write data_in to address 0, set count to 1, clear error_out, enter RECEIVING (or SENDING if final_in also high).
REQ-016 SHALL, in RECEIVING, write each transferred block to address count and increment count; no gaps required between beats, valid_in low cycles are idle.
REQ-017 SHALL, on a transfer with final_in high, enter SENDING next cycle with ready_out low.
REQ-018 SHALL, when count == DEPTH and a further non-final beat transfers, drop the block, hold count, set error_out; a final beat at count == DEPTH is also dropped and ends reception.
REQ-019 SHALL ignore valid_in and final_in whenever ready_out is low.
REQ-020 SHALL, in SENDING, assert first valid_out no later than 3 cycles after entering SENDING and emit exactly count blocks, addresses 0..count-1.
REQ-021 SHALL hold data_out, valid_out, final_out stable while valid_out && !ready_in; SHALL sustain one block per cycle while ready_in is continuously high after the first valid_out.
REQ-022 SHALL assert final_out with the block at address count-1, and return to IDLE the cycle after it transfers; ready_out high that cycle.
REQ-023 SHALL keep error_out stable from set until the next IDLE-state first-beat transfer or reset.
REQ-024 SHALL store blocks in inferable block RAM of DEPTH x REGISTER_SIZE; address width $clog2(DEPTH).

Reset
REQ-025 SHALL, when rst_in is low at a clock edge, enter IDLE, clear count, force ready_out=1 after release, valid_out=0, final_out=0, error_out=0, data_out=0.
REQ-026 SHALL abandon any in-progress reception or transmission on reset; memory contents need not be cleared.

Configuration
REQ-027 SHALL support macro COLLECTOR_LENGTH_CHECK_EN: when defined, a final beat arriving with resulting count != DEPTH sets error_out (stream still emitted with its received count).
REQ-028 SHALL, without COLLECTOR_LENGTH_CHECK_EN, set error_out only on overflow per REQ-018; short streams are not errors.

Verification
REQ-029 SHALL cover: 256 beats data=i (0..255), final on beat 255, ready_in=1 -> 256 outputs 0..255 in order, final_out on 255, error_out=0, back in IDLE.
REQ-030 SHALL cover: same stream with ready_in toggling 1,0,0,1 repeating -> data_out held during stalls, no duplicates or losses, 256 outputs.
REQ-031 SHALL cover: 10-beat stream 0xA0..0xA9 final on 10th -> 10 outputs; error_out=1 with COLLECTOR_LENGTH_CHECK_EN, 0 without.
REQ-032 SHALL cover: 258 beats, final on 258th -> 256 outputs 0..255, error_out=1 in both builds.
REQ-033 SHALL cover: rst_in low for 1 cycle after 100 received beats -> valid_out=0, ready_out=1, new 256-beat stream then emitted correctly with error_out=0.
REQ-034 SHALL cover: single beat 0xDEADBEEF with valid_in and final_in together in IDLE -> one output 0xDEADBEEF with final_out=1.
